// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM answering load/store requests after LATENCY cycles.
// Define DMEM_BYTE_EN to add the per-lane store enable port be.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]  be,
`endif
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        misalign
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t          r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic            r_we;
    logic [AW+1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_misalign;
    logic [31:0]     r_mem [DEPTH];
    logic            w_accept, w_enter, w_we, w_mis, w_wr, w_unused;
    logic [AW+1:0]   w_addr;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_wdata;
    logic [3:0]      w_be;
    assign w_unused = ^addr[31:AW+2];
    assign w_accept = (r_state == IDLE) && req;
    // With LATENCY=1 the RESP edge is the accepting edge, so take the live inputs then.
    assign w_we    = (r_state == IDLE) ? we : r_we;
    assign w_addr  = (r_state == IDLE) ? addr[AW+1:0] : r_addr;
    assign w_wdata = (r_state == IDLE) ? wdata : r_wdata;
    assign w_mis   = |w_addr[1:0];
    assign w_idx   = w_addr[AW+1:2];
    assign w_wr    = reset && w_enter && w_we && !w_mis;
`ifdef DMEM_BYTE_EN
    logic [3:0] r_be;
    assign w_be = (r_state == IDLE) ? be : r_be;
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            r_be <= '0;
        else if (w_accept)
            r_be <= be;
`else
    assign w_be = 4'hf;
`endif
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_enter     = 1'b0;
        if (w_accept) begin
            w_enter     = (LATENCY == 1);
            w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
            w_cnt_nxt   = 4'(LATENCY - 1);
        end else if (r_state == WAIT) begin
            w_cnt_nxt   = r_cnt - 4'd1;
            w_enter     = (r_cnt == 4'd1);
            w_state_nxt = w_enter ? RESP : WAIT;
        end else if (r_state == RESP) begin
            w_state_nxt = IDLE;
        end
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= we;
                r_addr  <= addr[AW+1:0];
                r_wdata <= wdata;
            end
            r_rdata    <= (w_enter && !w_we && !w_mis) ? r_mem[w_idx] : '0;
            r_misalign <= w_enter && w_mis;
        end
    always_ff @(posedge clk)
        if (w_wr)
            for (int i = 0; i < 4; i++)
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
    assign rdata    = r_rdata;
    assign ready    = (r_state == RESP);
    assign busy     = (r_state != IDLE);
    assign misalign = r_misalign;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder against a word-array model.
module tb_dmem_responder;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int AW      = $clog2(DEPTH);
    typedef struct {
        logic [31:0] d;
        logic        m;
        int          c;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = 4'hf;
    logic [31:0] rdata;
    logic        ready, busy, misalign;
    logic [31:0] mem [DEPTH];
    exp_t        q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .we(we),
        .addr(addr),
        .wdata(wdata),
`ifdef DMEM_BYTE_EN
        .be(be),
`endif
        .rdata(rdata),
        .ready(ready),
        .busy(busy),
        .misalign(misalign)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    always @(negedge clk)
        if (reset && ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: got ready=1 expected no pending access");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rdata", rdata, e.d);
                chk("misalign", 32'(misalign), 32'(e.m));
                chk("ready_cycle", cyc, e.c);
                chk("busy_in_resp", 32'(busy), 32'd1);
            end
        end
    // Called on a negedge; waits for IDLE (optionally spraying ignored requests) then issues one access.
    task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input bit junk);
        int   n = 0;
        int   i;
        logic [3:0] eb;
        exp_t e;
        while (busy) begin
            req   = junk ? 1'($urandom) : 1'b0;
            we    = 1'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            be    = 4'($urandom);
            @(negedge clk);
            n++;
            if (n > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL busy_timeout: got busy=1 after %0d cycles expected idle", n);
                break;
            end
        end
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
`ifdef DMEM_BYTE_EN
        eb = b;
`else
        eb = 4'hf;
`endif
        i   = int'(a[AW+1:2]);
        e.c = cyc + LATENCY;
        e.m = (a[1:0] != 2'b00);
        e.d = '0;
        if (!e.m && w) begin
            for (int k = 0; k < 4; k++)
                if (eb[k]) mem[i][8*k +: 8] = d[8*k +: 8];
        end else if (!e.m) begin
            e.d = mem[i];
        end
        q.push_back(e);
        @(negedge clk);
        req = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask
    initial begin
        logic [31:0] a;
        logic [31:0] old;
        #1 reset = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            do_op(1'b1, 32'(i * 4), $urandom, 4'hf, 1'b0);
        do_op(1'b1, 32'h10, 32'hDEADBEEF, 4'hf, 1'b0);
        do_op(1'b0, 32'h10, 32'h0, 4'hf, 1'b0);
        do_op(1'b0, 32'h44, 32'h0, 4'hf, 1'b0);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h0BADBAD0;
        @(negedge clk);
        do_op(1'b0, 32'h20, 32'h0, 4'hf, 1'b0);
        do_op(1'b1, 32'h13, 32'h12345678, 4'hf, 1'b0);
        do_op(1'b0, 32'h10, 32'h0, 4'hf, 1'b0);
        do_op(1'b1, 32'h404, 32'hCAFEF00D, 4'hf, 1'b0);
        do_op(1'b0, 32'h004, 32'h0, 4'hf, 1'b0);
        // Reset during the RESP cycle of a load must drop ready and rdata at once.
        do_op(1'b0, 32'h10, 32'h0, 4'hf, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_resp_ready", 32'(ready), 32'd0);
        chk("rst_resp_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        old = mem[12];
        do_op(1'b1, 32'h30, 32'h55AA55AA, 4'hf, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("rst_wait_busy", 32'(busy), 32'd0);
        chk("rst_wait_ready", 32'(ready), 32'd0);
        chk("rst_wait_misalign", 32'(misalign), 32'd0);
        chk("rst_wait_rdata", rdata, 32'd0);
        q.delete();
        mem[12] = old;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_op(1'b0, 32'h30, 32'h0, 4'hf, 1'b0);
`ifdef DMEM_BYTE_EN
        do_op(1'b1, 32'h40, 32'hFFFFFFFF, 4'hf, 1'b0);
        do_op(1'b1, 32'h40, 32'h11223344, 4'b0101, 1'b0);
        do_op(1'b0, 32'h40, 32'h0, 4'hf, 1'b0);
        do_op(1'b1, 32'h40, 32'h0, 4'b0000, 1'b0);
        do_op(1'b0, 32'h40, 32'h0, 4'hf, 1'b0);
`endif
        for (int n = 0; n < 400; n++) begin
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            do_op(1'($urandom), a, $urandom, 4'($urandom), 1'b1);
            if ($urandom_range(3) == 0) @(negedge clk);
        end
        for (int k = 0; k < 100 && (q.size() > 0 || busy); k++) @(negedge clk);
        chk("drain_pending", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the single-cycle MIPS core's load/store port.
- Consumes the address (ALUResult), store data (WriteData) and write strobe from the datapath. Returns ReadData after a fixed, configurable wait-state latency.
- Raises a one-cycle ready pulse that the core's stall logic uses to freeze PC during a memory access.
- Word-organised synchronous RAM behind a small request/response FSM.

Parameters:
- DEPTH, 256, number of 32-bit words; power of 2; index width AW = log2(DEPTH).
- LATENCY, 2, cycles from request acceptance to the ready pulse; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = store, 0 = load; sampled with req.
- addr  input  32  byte address; word index = addr[AW+1:2].
- wdata  input  32  store data; sampled with req.
- rdata  output  32  load data; valid only while ready=1.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high in WAIT and RESP.
- misalign  output  1  error flag; valid only while ready=1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, ready=0, busy=0, misalign=0, rdata=0, request latches cleared. RAM contents are not reset.
- Reset asserted mid-access: the pending store is discarded and the RAM is left unmodified. The first request after reset deassertion is accepted normally.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with req=1, latch we, addr and wdata.
  - If LATENCY=1, go to RESP; otherwise load counter=LATENCY-1 and go to WAIT.
  - req=0 stays in IDLE.
- WAIT: decrement the counter each edge. On the edge where counter==1, go to RESP.
- RESP: ready=1 for exactly one cycle, then unconditionally return to IDLE.
- Timing rule: ready is high exactly LATENCY cycles after the accepting edge. Throughput is at most one access per LATENCY+1 cycles.
- req, we, addr and wdata are ignored in WAIT and RESP. No queueing; the master must hold or re-assert req.
- Store: RAM[index] <= latched wdata on the edge entering RESP. rdata=0 during a store's ready pulse.
- Load: rdata = RAM[index] registered on the edge entering RESP, held only through RESP, and returned to 0 in IDLE.
- Misalignment: latched addr[1:0] != 0 gives misalign=1 with ready. No RAM write occurs and rdata=0.
- Addressing: bits above addr[AW+1] are ignored, so addresses wrap modulo DEPTH*4. Example with DEPTH=256: 0x400 aliases 0x000.
- busy = (state != IDLE). It is combinational from the state register.

Optional Feature:
- Macro DMEM_BYTE_EN.
- Defined:
  - Adds port be, input, 4 bits, sampled with req. Store writes only the byte lanes with be[i]=1; lane i = bits 8i+7:8i.
  - be=0000 completes with ready but writes nothing.
  - Misalignment check is still word-based.
- Undefined: no be port; every store writes all 32 bits.

Test Plan:
- Store/load, LATENCY=2: store addr=0x10, wdata=0xDEADBEEF at edge T gives ready at T+2 with no misalign. Then load 0x10 gives rdata=0xDEADBEEF with ready exactly 2 cycles after acceptance; busy is high for the 2 intervening cycles.
- Ignored request: assert req with a store to 0x20 during WAIT of a prior access. That store must not occur; a later load of 0x20 returns its prior contents.
- Misaligned access: store addr=0x13, wdata=0x12345678 gives ready and misalign=1. A load of 0x10 afterwards is unchanged.
- Wrap, DEPTH=256: store 0x404 with 0xCAFEF00D, then load 0x004 returns 0xCAFEF00D.
- Reset mid-operation: store 0x30 with 0x55AA55AA, then pull reset low during WAIT.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a load of 0x30 returns its pre-store value and is accepted at the first req edge.
- DMEM_BYTE_EN defined: store 0x40 with 0xFFFFFFFF and be=1111, then store 0x11223344 with be=0101. A load of 0x40 returns 0xFF22FF44.
